// File: rtl/output_arb_pkg.sv
// Shared types and constants for the two-input output-port arbiter.
package output_arb_pkg;

  localparam int unsigned WIDTH_packet = 14;
  localparam int unsigned STATS_W      = 16;

  typedef logic [WIDTH_packet-1:0] pkt_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/output_arb_pkt_fifo.sv
// Small circular-buffer FIFO with wrap-bit pointers; no empty bypass.
module pkt_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty   = (wr_ptr == rd_ptr);
  // A full FIFO refuses a write even while it is being read.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/output_arb.sv
// Two-input round-robin output-port arbiter with per-input FIFOs and a registered output.
// Optional grant counters are enabled by defining OUTPUT_ARB_STATS_EN.
module output_arb #(
  parameter int unsigned WIDTH_packet = output_arb_pkg::WIDTH_packet,
  parameter int unsigned DEPTH        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH_packet-1:0] in0_data,
  input  logic                    in0_valid,
  output logic                    in0_ready,
  input  logic [WIDTH_packet-1:0] in1_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  output logic [WIDTH_packet-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef OUTPUT_ARB_STATS_EN
  output logic                    out_src,
  output logic [output_arb_pkg::STATS_W-1:0] grant_cnt0,
  output logic [output_arb_pkg::STATS_W-1:0] grant_cnt1
`else
  output logic                    out_src
`endif
);

  import output_arb_pkg::*;

  logic [WIDTH_packet-1:0] dout0, dout1;
  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;

  out_state_t state, state_nxt;
  logic       last_grant;
  logic       grant;
  logic       do_grant;
  logic       load;

  assign in0_ready = !full0;
  assign in1_ready = !full1;
  assign push0     = in0_valid && in0_ready;
  assign push1     = in1_valid && in1_ready;
  assign out_valid = (state == HOLD);

  pkt_fifo #(.WIDTH(WIDTH_packet), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .din   (in0_data),
    .pop   (pop0),
    .dout  (dout0),
    .full  (full0),
    .empty (empty0)
  );

  pkt_fifo #(.WIDTH(WIDTH_packet), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .din   (in1_data),
    .pop   (pop1),
    .dout  (dout1),
    .full  (full1),
    .empty (empty1)
  );

  always_comb begin
    load      = (state == EMPTY) || (out_valid && out_ready);
    do_grant  = load && (!empty0 || !empty1);
    // With both heads waiting the loser of the previous grant wins; otherwise the non-empty one.
    grant     = (!empty0 && !empty1) ? ~last_grant : empty0;
    pop0      = do_grant && !grant;
    pop1      = do_grant && grant;
    state_nxt = state;
    if (load) state_nxt = do_grant ? HOLD : EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        out_data   <= grant ? dout1 : dout0;
        out_src    <= grant;
        last_grant <= grant;
      end
    end
  end

`ifdef OUTPUT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (pop0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (pop1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: doc/output_arb.md
# output_arb

Clocked two-input output-port arbiter for a NoC tree router node. It buffers packets from two child/sibling links in small per-input FIFOs. A round-robin arbiter then shares one outgoing link between them, fairly and without loss. It is the synchronous counterpart of the router's two-to-one output control stage and sits directly in front of each upward/downward link driver.

## Interface
- WIDTH_packet, 14, packet width in bits; the packet is opaque to this block.
- DEPTH, 2, entries per input FIFO; must be a power of two and at least 2.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0_data  input  WIDTH_packet  packet from requester 0
- in0_valid  input  1  requester 0 offers in0_data
- in0_ready  output  1  FIFO 0 not full
- in1_data / in1_valid / in1_ready  same as the in0 signals, for requester 1
- out_data  output  WIDTH_packet  granted packet
- out_valid  output  1  out_data holds a packet
- out_ready  input  1  downstream accepts
- out_src  output  1  index of the input that supplied out_data

## Operation
- Reset: one clock, asynchronous active-low reset.
  - Both FIFOs are emptied and any buffered packets are dropped.
  - Reset values: out_valid=0, out_data=0, out_src=0, in0_ready=in1_ready=1.
  - The round-robin pointer is reset to last_grant=1, so input 0 wins the first contention.
- Input handshake:
  - A transfer occurs on a rising edge when inX_valid && inX_ready.
  - inX_ready = !fullX. It is a pure register function with no combinational path from any input.
  - A full FIFO refuses a write even in a cycle where it is being read.
- Output register states:
  - EMPTY (out_valid=0).
  - HOLD (out_valid=1).
- Load condition: load = (state==EMPTY) || (out_valid && out_ready).
- Arbitration on a load cycle:
  - Candidates are the non-empty FIFOs.
  - If both are non-empty, grant the input != last_grant.
  - If only one is non-empty, grant it.
  - The granted FIFO is popped, its head goes into out_data, out_src is set to the grant, and last_grant is updated.
- State transitions:
  - EMPTY→HOLD on a grant.
  - HOLD→HOLD on drain plus a new grant.
  - HOLD→EMPTY on drain with no candidate.
  - HOLD stays on !out_ready. out_data and out_src are held stable and no FIFO is popped.
- last_grant changes only on an actual grant. An idle cycle does not advance it.
- FIFO behaviour:
  - Circular buffer with wrapping pointers of log2(DEPTH) bits plus one extra wrap bit.
  - full = (wr_ptr ^ rd_ptr) == {1'b1, zeros}.
  - empty = (wr_ptr == rd_ptr).
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the occupancy unchanged.
  - There is no empty-FIFO bypass.

## Timing
- Latency: a packet accepted at edge N is visible with out_valid=1 after edge N+1, provided the output is free and the packet wins arbitration.
- Throughput: one packet per cycle on the output while out_ready=1 and any FIFO is non-empty.
- Under continuous contention the grants alternate 0,1,0,1.
- Worst-case wait for a head packet with out_ready held at 1 is 1 cycle of the other input.
- in_ready falls on the edge at which the FIFO becomes full. It rises on the edge after the pop that frees an entry.
- Reset asserted mid-HOLD: out_valid drops immediately (asynchronously) and the in-flight packet is lost.

## Configuration
- OUTPUT_ARB_STATS_EN:
  - Defined: adds output ports grant_cnt0 and grant_cnt1, each 16 bits, with reset value 0.
    - Each counter increments on every grant to its input.
    - Each counter saturates at 16'hFFFF.
  - Undefined: the ports and counters are absent. Arbitration behaviour is identical in both cases.

## Structure
- Shared package output_arb_pkg:
  - WIDTH_packet default.
  - typedef pkt_t (logic [WIDTH_packet-1:0]).
  - typedef enum {EMPTY, HOLD} out_state_t.
  - STATS_W = 16.
- Sub-module pkt_fifo (parameters WIDTH, DEPTH; ports clk, rst_n, push, din, pop, dout, full, empty), instantiated twice.
- The arbiter and output register live in output_arb itself.

## Test plan
- Post-reset check:
  - in0_ready=in1_ready=1 and out_valid=0.
  - Send 14'h2820 on in0 with out_ready=1 → out_data=14'h2820 and out_src=0 one cycle after the accept edge.
- Input 1 alone:
  - 14'h17C0 on in1 with in0 idle → out_data=14'h17C0 and out_src=1.
  - last_grant becomes 1.
- Contention:
  - 14'h1ABE on in0 and 14'h313E on in1 in the same cycle, out_ready=1, after reset → output order 1ABE (src 0) then 313E (src 1) on consecutive cycles.
  - Repeat the same stimulus with last_grant=0 → order 313E then 1ABE.
- Backpressure:
  - Hold out_ready=0 and push 3 packets into in0 with DEPTH=2.
  - Required: out_data holds the first packet stable.
  - Required: in0_ready=0 once FIFO 0 is full.
  - Release out_ready → all 3 packets appear in order, with no loss or duplication.
- Streaming: both inputs stream 8 packets each back-to-back with out_ready=1 → 16 output beats, strictly alternating src, no idle cycle.
- Reset mid-operation and stats:
  - Assert rst_n=0 during HOLD with both FIFOs non-empty → out_valid=0 immediately and, after release, no stale packet appears.
  - With OUTPUT_ARB_STATS_EN defined, counters read 0 after reset and equal the per-input grant totals after the streaming test.
